// File: rtl/period_meter_if.sv
// Connects period_meter to its user: the measured signal and the controls in,
// the captured period and status out.
// valid and timeout are single-cycle strobes with no back-pressure: period_ms is
// correct in the cycle valid is high and holds until the next capture. busy is a level.
interface period_meter_if #(
  parameter int W = 16
);
  logic         sig_in;
  logic         start;
  logic         cont;
  logic [W-1:0] period_ms;
  logic         valid;
  logic         timeout;
  logic         busy;

  modport master (
    output sig_in, start, cont,
    input  period_ms, valid, timeout, busy
  );

  modport slave (
    input  sig_in, start, cont,
    output period_ms, valid, timeout, busy
  );
endinterface

// File: rtl/period_meter.sv
// Measures the spacing between rising edges of a slow asynchronous signal in whole
// milliseconds, using a millisecond prescaler clocked from clk.
module period_meter #(
  parameter int CLK_PER_MS = 100000,
  parameter int TIMEOUT_MS = 5000,
  parameter int W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  period_meter_if.slave     bus,
  output logic [1:0]        state_dbg
);
  localparam int            PW       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [W-1:0]  MS_LIMIT = W'(TIMEOUT_MS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          s1, s2, s3;
  logic [PW-1:0] pre;
  logic [W-1:0]  msc;
  logic          edge_det, tick, limit;
  logic          clr, cap, to_evt;

  assign edge_det  = s2 & ~s3;
  assign tick      = (pre == PRE_LAST);
  assign limit     = (msc == MS_LIMIT);
  assign state_dbg = state;
  assign bus.busy  = (state != IDLE);

  // An edge is checked before the timeout limit so a coincident edge still reports.
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    cap      = 1'b0;
    to_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = ARM;
          clr      = 1'b1;
        end
      end
      ARM: begin
        if (edge_det) begin
          state_nx = MEASURE;
          clr      = 1'b1;
        end else if (limit) begin
          state_nx = IDLE;
          to_evt   = 1'b1;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          cap = 1'b1;
          if (bus.cont) clr      = 1'b1;
          else          state_nx = IDLE;
        end else if (limit) begin
          state_nx = IDLE;
          to_evt   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      pre           <= '0;
      msc           <= '0;
      bus.period_ms <= '0;
      bus.valid     <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      state <= state_nx;
      s1    <= bus.sig_in;
      s2    <= s1;
      s3    <= s2;
      // A clear overrides a coincident tick, so that tick is never counted.
      if (clr) begin
        pre <= '0;
        msc <= '0;
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick && (state != IDLE)) msc <= msc + 1'b1;
      end
      bus.valid   <= cap;
      bus.timeout <= to_evt;
      if (cap) bus.period_ms <= msc;
    end
  end
endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: the driver pushes expected events (kind, period, cycle)
// and a forked monitor pops and compares them whenever valid or timeout strobes.
module tb_period_meter;
  localparam int C = 10;
  localparam int T = 20;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct packed {
    logic         is_to;
    logic [W-1:0] per;
    logic [31:0]  at;
  } exp_t;

  exp_t exp_q[$];

  period_meter_if #(.W(W)) bus ();

  period_meter #(
    .CLK_PER_MS(C),
    .TIMEOUT_MS(T),
    .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Rising edge of sig_in at this negedge; the capture registers 3 posedges later.
  task automatic rise(input bit push, input logic [W-1:0] p);
    if (push) exp_q.push_back(exp_t'{is_to: 1'b0, per: p, at: 32'(cyc + 3)});
    bus.sig_in = 1'b1;
    tick_n(3);
    bus.sig_in = 1'b0;
  endtask

  task automatic send_edges(input int n, input int gap, input logic [W-1:0] p, input bit push_first);
    for (int i = 0; i < n; i++) begin
      rise((i > 0) || push_first, p);
      tick_n(gap - 3);
    end
  endtask

  task automatic expect_timeout(input logic [W-1:0] p, input int at);
    exp_q.push_back(exp_t'{is_to: 1'b1, per: p, at: 32'(at)});
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"},   int'(bus.valid),     0);
    chk({tag, "_timeout"}, int'(bus.timeout),   0);
    chk({tag, "_busy"},    int'(bus.busy),      0);
    chk({tag, "_period"},  int'(bus.period_ms), 0);
    chk({tag, "_state"},   int'(state_dbg),     0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if ((bus.valid === 1'b1) || (bus.timeout === 1'b1)) begin
        chk("both_strobes", int'(bus.valid & bus.timeout), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event valid %0d timeout %0d period %0d cycle %0d required none",
                   bus.valid, bus.timeout, bus.period_ms, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind",  int'(bus.timeout),   int'(e.is_to));
          chk("event_period", int'(bus.period_ms), int'(e.per));
          chk("event_cycle", cyc, int'(e.at));
        end
      end
    end
  endtask

  initial begin
    bus.sig_in = 1'b0;
    bus.start  = 1'b0;
    bus.cont   = 1'b0;
    rst        = 1'b1;
    fork
      monitor();
    join_none

    // Reset held 3 cycles with sig_in toggling.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_quiet("reset");
      bus.sig_in = ~bus.sig_in;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.sig_in = ~bus.sig_in;
      @(negedge clk);
    end
    bus.sig_in = 1'b0;
    tick_n(5);
    chk("idle_after_reset_busy",  int'(bus.busy), 0);
    chk("idle_after_reset_state", int'(state_dbg), 0);

    // Basic single capture, 55 cycles -> 5 ms.
    do_start();
    chk("busy_after_start", int'(bus.busy), 1);
    send_edges(2, 55, 8'd5, 1'b0);
    chk("basic_busy_low", int'(bus.busy), 0);
    chk("basic_period",   int'(bus.period_ms), 5);

    // Boundary: 50 cycles -> 4 (coincident tick lost), 51 -> 5.
    do_start();
    send_edges(2, 50, 8'd4, 1'b0);
    chk("b50_period", int'(bus.period_ms), 4);
    do_start();
    send_edges(2, 51, 8'd5, 1'b0);
    chk("b51_period", int'(bus.period_ms), 5);

    // Continuous: four 35-cycle periods, then drop cont for a final capture.
    bus.cont = 1'b1;
    do_start();
    send_edges(5, 35, 8'd3, 1'b0);
    chk("cont_still_busy", int'(bus.busy), 1);
    bus.cont = 1'b0;
    send_edges(1, 35, 8'd3, 1'b1);
    chk("cont_end_busy", int'(bus.busy), 0);

    // Timeout with no edges: period_ms holds 3.
    do_start();
    expect_timeout(8'd3, cyc + 201);
    tick_n(215);
    chk("to_arm_period", int'(bus.period_ms), 3);
    chk("to_arm_busy",   int'(bus.busy), 0);

    // Single edge then silence.
    do_start();
    expect_timeout(8'd3, cyc + 204);
    rise(1'b0, 8'd0);
    tick_n(230);
    chk("to_meas_busy",   int'(bus.busy), 0);
    chk("to_meas_period", int'(bus.period_ms), 3);

    // start pulsed mid-measurement is ignored.
    do_start();
    rise(1'b0, 8'd0);
    tick_n(17);
    do_start();
    chk("start_ignored_state", int'(state_dbg), 2);
    tick_n(34);
    rise(1'b1, 8'd5);
    tick_n(52);
    chk("start_ignored_busy", int'(bus.busy), 0);

    // Reset mid-measurement aborts silently.
    do_start();
    rise(1'b0, 8'd0);
    tick_n(20);
    rst = 1'b1;
    tick_n(1);
    chk_quiet("midrst");
    tick_n(1);
    rst = 1'b0;
    tick_n(250);
    chk("after_midrst_busy",   int'(bus.busy), 0);
    chk("after_midrst_period", int'(bus.period_ms), 0);
    do_start();
    send_edges(2, 51, 8'd5, 1'b0);
    chk("after_midrst_capture", int'(bus.period_ms), 5);

    tick_n(10);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
